// File: rtl/pls_gen_sec_if.sv
// ---------------------------------------------------------------------------
// pls_gen_sec_if
//   Bundles the control inputs and pulse outputs of pls_gen_sec.
//   master : drives run_btn / fast / clr, observes plso / tick / running
//   slave  : the pulse generator side
// Signals:
//   run_btn  raw run/stop push-button, active-high, asynchronous, bouncy
//   fast     1 = fast rate, 0 = normal rate (level, asynchronous)
//   clr      clear request (asynchronous, acts on its rising edge)
//   plso     50%-duty square wave to the downstream seconds counter
//   tick     one-cycle strobe in the cycle plso goes 1->0
//   running  1 while the generator is in RUN
// ---------------------------------------------------------------------------
interface pls_gen_sec_if;
    logic run_btn;
    logic fast;
    logic clr;
    logic plso;
    logic tick;
    logic running;

    modport master (
        output run_btn,
        output fast,
        output clr,
        input  plso,
        input  tick,
        input  running
    );

    modport slave (
        input  run_btn,
        input  fast,
        input  clr,
        output plso,
        output tick,
        output running
    );
endinterface

// File: rtl/pls_gen_sec.sv
// ---------------------------------------------------------------------------
// pls_gen_sec
//   Seconds pulse source. Divides clk into a 50%-duty square wave on plso,
//   with a debounced run/stop button, a fast-set rate select and a clear.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-low reset
//   bus   pls_gen_sec_if.slave
//           run_btn / fast / clr  : asynchronous inputs (2-FF synchronized)
//           plso                  : square wave, period DIV or FAST_DIV clk
//           tick                  : 1-cycle strobe on plso falling edge
//           running               : 1 while in RUN
//
// Parameters:
//   DIV       clk cycles per plso period at normal rate (even, >= 4)
//   FAST_DIV  clk cycles per plso period at fast rate (even, >= 4, <= DIV)
//   DEB_CYC   stability time of the synced button before it is accepted (>= 2)
//
// Configuration macro:
//   PLS_GEN_AUTORUN_EN  defined   -> reset state is RUN (running=1 at reset)
//                       undefined -> reset state is STOP, a press starts it
// ---------------------------------------------------------------------------
module pls_gen_sec #(
    parameter int unsigned DIV      = 50_000_000,
    parameter int unsigned FAST_DIV = 500_000,
    parameter int unsigned DEB_CYC  = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    pls_gen_sec_if.slave  bus
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef PLS_GEN_AUTORUN_EN
    localparam state_t RST_STATE = ST_RUN;
`else
    localparam state_t RST_STATE = ST_STOP;
`endif
    localparam logic RST_RUNNING = (RST_STATE == ST_RUN);

    localparam int SW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [SW-1:0] STAB_MAX     = SW'(DEB_CYC - 1);
    localparam logic [31:0]   HALF_M1_NORM = 32'(DIV / 2 - 1);
    localparam logic [31:0]   HALF_M1_FAST = 32'(FAST_DIV / 2 - 1);

    // Synchronizers
    logic btn_meta_q,  btn_meta_d,  btn_s_q,  btn_s_d;
    logic fast_meta_q, fast_meta_d, fast_s_q, fast_s_d;
    logic clr_meta_q,  clr_meta_d,  clr_s_q,  clr_s_d;
    logic clr_prev_q,  clr_prev_d;

    // Debouncer
    logic          cand_q, cand_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic          deb_q, deb_d;

    // FSM / divider
    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          plso_q, plso_d;
    logic          tick_q, tick_d;
    logic          running_q, running_d;

    logic          clr_rise;
    logic          press;
    logic [31:0]   half_m1;

    always_comb begin
        btn_meta_d  = bus.run_btn;
        btn_s_d     = btn_meta_q;
        fast_meta_d = bus.fast;
        fast_s_d    = fast_meta_q;
        clr_meta_d  = bus.clr;
        clr_s_d     = clr_meta_q;
        clr_prev_d  = clr_s_q;

        clr_rise = clr_s_q & ~clr_prev_q;

        // Debounce: any disagreement restarts the stability window with the
        // new level as candidate; once the window is full the counter parks
        // at STAB_MAX and keeps re-asserting the same level.
        cand_d     = cand_q;
        stab_cnt_d = stab_cnt_q;
        deb_d      = deb_q;
        if (btn_s_q != cand_q) begin
            cand_d     = btn_s_q;
            stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_MAX) begin
            deb_d = cand_q;
        end else begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end

        // A press is the 0->1 change of the debounced level, so a held button
        // toggles exactly once. Clear does not block it.
        press   = deb_d & ~deb_q;
        state_d = state_q;
        if (press) begin
            state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end
        running_d = (state_d == ST_RUN);

        // Rate can change mid half-period; the >= compare wraps immediately
        // if cnt is already past the new limit.
        half_m1 = fast_s_q ? HALF_M1_FAST : HALF_M1_NORM;

        cnt_d  = cnt_q;
        plso_d = plso_q;
        tick_d = 1'b0;
        if (clr_rise) begin
            // A falling plso here is not a counted edge: no tick.
            cnt_d  = '0;
            plso_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (cnt_q >= half_m1) begin
                cnt_d  = '0;
                plso_d = ~plso_q;
                tick_d = plso_q;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
        // In STOP cnt and plso hold, so resuming finishes the partial period.
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            fast_meta_q <= 1'b0;
            fast_s_q    <= 1'b0;
            clr_meta_q  <= 1'b0;
            clr_s_q     <= 1'b0;
            clr_prev_q  <= 1'b0;
            cand_q      <= 1'b0;
            stab_cnt_q  <= '0;
            deb_q       <= 1'b0;
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            plso_q      <= 1'b0;
            tick_q      <= 1'b0;
            running_q   <= RST_RUNNING;
        end else begin
            btn_meta_q  <= btn_meta_d;
            btn_s_q     <= btn_s_d;
            fast_meta_q <= fast_meta_d;
            fast_s_q    <= fast_s_d;
            clr_meta_q  <= clr_meta_d;
            clr_s_q     <= clr_s_d;
            clr_prev_q  <= clr_prev_d;
            cand_q      <= cand_d;
            stab_cnt_q  <= stab_cnt_d;
            deb_q       <= deb_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            plso_q      <= plso_d;
            tick_q      <= tick_d;
            running_q   <= running_d;
        end
    end

    assign bus.plso    = plso_q;
    assign bus.tick    = tick_q;
    assign bus.running = running_q;

endmodule

// File: tb/tb_pls_gen_sec.sv
// ---------------------------------------------------------------------------
// tb_pls_gen_sec
//   Self-checking bench for pls_gen_sec with DIV=8, FAST_DIV=4, DEB_CYC=3.
//   Inputs are driven between clock edges; after every rising edge the DUT
//   outputs are compared with a behavioural model built from input history,
//   run lengths of the synced button and elapsed time within a half period.
// ---------------------------------------------------------------------------
module tb_pls_gen_sec;

    localparam int DIV      = 8;
    localparam int FAST_DIV = 4;
    localparam int DEB_CYC  = 3;

`ifdef PLS_GEN_AUTORUN_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic clk;
    logic rst_n;

    pls_gen_sec_if bus_if ();

    pls_gen_sec #(
        .DIV      (DIV),
        .FAST_DIV (FAST_DIV),
        .DEB_CYC  (DEB_CYC)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc;

    // ---------------- reference model state ----------------
    // *_h[0] is the sample taken at the latest edge, [1] the one before, ...
    logic [3:0] m_btn_h, m_fast_h, m_clr_h;
    logic       m_last;      // level of the current run of the synced button
    int         m_run_len;   // edges that have seen that level in a row
    logic       m_deb;
    logic       m_run;
    int         m_elapsed;   // clk spent in the current half period
    logic       m_plso;
    logic       m_tick;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_btn_h   = '0;
        m_fast_h  = '0;
        m_clr_h   = '0;
        m_last    = 1'b0;
        m_run_len = 1;
        m_deb     = 1'b0;
        m_run     = AUTO;
        m_elapsed = 0;
        m_plso    = 1'b0;
        m_tick    = 1'b0;
    endtask

    // One rising clock edge; b/f/c are the raw input levels sampled there.
    task automatic model_step(input logic b, input logic f, input logic c);
        logic fast_synced;
        logic clr_rise;
        logic deb_new;
        int   half;
        // Synced value seen by the logic at this edge is the sample two edges old.
        fast_synced = m_fast_h[1];
        clr_rise    = m_clr_h[1] & ~m_clr_h[2];
        half        = fast_synced ? FAST_DIV / 2 : DIV / 2;

        m_tick = 1'b0;
        if (clr_rise) begin
            m_elapsed = 0;
            m_plso    = 1'b0;
        end else if (m_run) begin
            if (m_elapsed + 1 >= half) begin
                m_elapsed = 0;
                m_tick    = m_plso;
                m_plso    = ~m_plso;
            end else begin
                m_elapsed++;
            end
        end

        // Accept a level once DEB_CYC+1 consecutive edges have seen it.
        if (m_btn_h[1] == m_last) m_run_len++;
        else begin
            m_last    = m_btn_h[1];
            m_run_len = 1;
        end
        deb_new = m_deb;
        if (m_run_len >= DEB_CYC + 1) deb_new = m_last;
        if (deb_new && !m_deb) m_run = ~m_run;
        m_deb = deb_new;

        m_btn_h  = {m_btn_h[2:0],  b};
        m_fast_h = {m_fast_h[2:0], f};
        m_clr_h  = {m_clr_h[2:0],  c};
    endtask

    task automatic do_cycle(input logic b, input logic f, input logic c);
        bus_if.run_btn = b;
        bus_if.fast    = f;
        bus_if.clr     = c;
        @(posedge clk);
        cyc++;
        model_step(b, f, c);
        #1;
        check_eq("plso",    {31'd0, bus_if.plso},    {31'd0, m_plso});
        check_eq("tick",    {31'd0, bus_if.tick},    {31'd0, m_tick});
        check_eq("running", {31'd0, bus_if.running}, {31'd0, m_run});
    endtask

    task automatic run_cycles(input string what, input logic b, input logic f,
                              input logic c, input int n);
        $display("cyc=%0d %s btn=%0b fast=%0b clr=%0b n=%0d", cyc, what, b, f, c, n);
        for (int i = 0; i < n; i++) do_cycle(b, f, c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_plso"},    {31'd0, bus_if.plso},    32'd0);
        check_eq({tag, "_tick"},    {31'd0, bus_if.tick},    32'd0);
        check_eq({tag, "_running"}, {31'd0, bus_if.running}, {31'd0, AUTO});
    endtask

    initial begin
        logic rb, rf;
        int   hold;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_n          = 1'b0;
        bus_if.run_btn = 1'b0;
        bus_if.fast    = 1'b0;
        bus_if.clr     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Idle
        run_cycles("idle", 1'b0, 1'b0, 1'b0, 40);
        // Clean press, normal rate
        run_cycles("press", 1'b1, 1'b0, 1'b0, 10);
        run_cycles("release", 1'b0, 1'b0, 1'b0, 30);
        // Bounce then held
        run_cycles("bounce", 1'b1, 1'b0, 1'b0, 1);
        run_cycles("bounce", 1'b0, 1'b0, 1'b0, 1);
        run_cycles("bounce", 1'b1, 1'b0, 1'b0, 1);
        run_cycles("bounce", 1'b0, 1'b0, 1'b0, 1);
        run_cycles("held", 1'b1, 1'b0, 1'b0, 10);
        run_cycles("release", 1'b0, 1'b0, 1'b0, 15);
        run_cycles("press", 1'b1, 1'b0, 1'b0, 10);
        run_cycles("release", 1'b0, 1'b0, 1'b0, 20);
        // Fast rate on/off
        run_cycles("fast_on", 1'b0, 1'b1, 1'b0, 20);
        run_cycles("fast_off", 1'b0, 1'b0, 1'b0, 20);
        // Clear while running
        run_cycles("clr", 1'b0, 1'b0, 1'b1, 1);
        run_cycles("clr_low", 1'b0, 1'b0, 1'b0, 12);
        run_cycles("clr", 1'b0, 1'b0, 1'b1, 2);
        run_cycles("clr_low", 1'b0, 1'b0, 1'b0, 12);

        // Asynchronous reset between edges
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("cyc=%0d async reset mid-period", cyc);
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        run_cycles("post_reset", 1'b0, 1'b0, 1'b0, 12);

        // Randomized phase
        rb = 1'b0;
        rf = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) < 3) hold = 1;
            else hold = $urandom_range(4, 30);
            rb = ~rb;
            if ($urandom_range(0, 5) == 0) rf = ~rf;
            run_cycles("rand", rb, rf, 1'b0, hold);
            if ($urandom_range(0, 7) == 0)
                run_cycles("rand_clr", rb, rf, 1'b1, $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
